// File: rtl/readburst_arbiter.sv
// readburst_arbiter: two-port readburst channel arbiter; define READBURST_ARB_RR_EN for round-robin, else port A has fixed priority
module readburst_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_readburst_do,
  output logic        a_readburst_done,
  input  logic [31:0] a_readburst_address,
  input  logic [1:0]  a_readburst_dword_length,
  input  logic [3:0]  a_readburst_byte_length,
  output logic [95:0] a_readburst_data,
  input  logic        b_readburst_do,
  output logic        b_readburst_done,
  input  logic [31:0] b_readburst_address,
  input  logic [1:0]  b_readburst_dword_length,
  input  logic [3:0]  b_readburst_byte_length,
  output logic [95:0] b_readburst_data,
  output logic        resp_readburst_do,
  input  logic        resp_readburst_done,
  output logic [31:0] resp_readburst_address,
  output logic [1:0]  resp_readburst_dword_length,
  output logic [3:0]  resp_readburst_byte_length,
  input  logic [95:0] resp_readburst_data
);
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
  state_t state, state_nxt;
  logic last_grant, ld, sel_b, pick_b;
`ifdef READBURST_ARB_RR_EN
  assign pick_b = b_readburst_do & (~a_readburst_do | ~last_grant);
`else
  assign pick_b = ~a_readburst_do;
`endif
  always_comb begin
    state_nxt = state;
    ld = 1'b0;
    sel_b = 1'b0;
    case (state)
      IDLE: begin
        ld = a_readburst_do | b_readburst_do;
        sel_b = pick_b;
      end
      GRANT_A: begin
        ld = resp_readburst_done & b_readburst_do;
        sel_b = 1'b1;
        state_nxt = resp_readburst_done ? IDLE : GRANT_A;
      end
      GRANT_B: begin
        ld = resp_readburst_done & a_readburst_do;
        state_nxt = resp_readburst_done ? IDLE : GRANT_B;
      end
      default: state_nxt = IDLE;
    endcase
    if (ld) state_nxt = sel_b ? GRANT_B : GRANT_A;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b0;
      resp_readburst_address <= '0;
      resp_readburst_dword_length <= '0;
      resp_readburst_byte_length <= '0;
    end else begin
      state <= state_nxt;
      if (ld) begin
        last_grant <= sel_b;
        resp_readburst_address <= sel_b ? b_readburst_address : a_readburst_address;
        resp_readburst_dword_length <= sel_b ? b_readburst_dword_length : a_readburst_dword_length;
        resp_readburst_byte_length <= sel_b ? b_readburst_byte_length : a_readburst_byte_length;
      end
    end
  end
  assign resp_readburst_do = state != IDLE;
  assign a_readburst_done = (state == GRANT_A) & resp_readburst_done;
  assign b_readburst_done = (state == GRANT_B) & resp_readburst_done;
  assign a_readburst_data = resp_readburst_data;
  assign b_readburst_data = resp_readburst_data;
endmodule
